// File: rtl/ttl_pkg.sv
// Shared definitions for the serial TTL link (receive path; transmit to follow).
// Line levels, default bit-period divider and the receiver state encoding.
package ttl_pkg;

    localparam int               CNT_W    = 13;
    localparam logic [CNT_W-1:0] BAUD_DIV = 13'd2604;

    localparam logic IDLE  = 1'b1;
    localparam logic START = 1'b0;
    localparam logic STOP  = 1'b1;

    typedef enum logic [2:0] {
        s_idle,
        s_start,
        s_data,
        s_stop,
        s_wait
    } rx_state_e;

endpackage

// File: rtl/ttl_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
// Both stages reset to 1 so a line at rest never looks like a start bit.
module ttl_sync (
    input  logic clk,
    input  logic rst_l,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/ttl_recv.sv
// 8N1 serial receiver: mid-bit sampling, LSB-first reassembly,
// valid/rd hand-off with framing-error pulse and sticky overrun.
module ttl_recv #(
    parameter int               CNT_W    = ttl_pkg::CNT_W,
    parameter logic [CNT_W-1:0] BAUD_DIV = ttl_pkg::BAUD_DIV,
    parameter logic [CNT_W-1:0] HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] byte_out,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    import ttl_pkg::*;

    logic rx_s;

    ttl_sync u_sync (
        .clk   (clk),
        .rst_l (rst_l),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             done;
    logic             accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ferr_d  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            s_idle: begin
                cnt_d = '0;
                if (rx_s == START) begin
                    state_d = s_start;
                end
            end
            s_start: begin
                if (cnt_q == HALF_DIV) begin
                    cnt_d   = '0;
                    state_d = (rx_s == START) ? s_data : s_idle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            s_data: begin
                if (cnt_q == BAUD_DIV) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 4'd7) begin
                        bit_d   = '0;
                        state_d = s_stop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            s_stop: begin
                if (cnt_q == BAUD_DIV) begin
                    cnt_d = '0;
                    if (rx_s == STOP) begin
                        done    = 1'b1;
                        state_d = s_idle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = s_wait;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            s_wait: begin
                // hold off until the line is released, so a break is one error
                cnt_d = '0;
                if (rx_s == IDLE) begin
                    state_d = s_idle;
                end
            end
            default: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = s_idle;
            end
        endcase
    end

    assign accept = rd && valid_q;

    always_comb begin
        byte_d  = byte_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (done) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !rd) begin
                ovr_d = 1'b1;
            end else if (accept) begin
                ovr_d = 1'b0;
            end
        end else if (accept) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= s_idle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign byte_out  = byte_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != s_idle);

endmodule

// File: tb/tb_ttl_recv.sv
// Directed bench for ttl_recv: fast instance (16 clk/bit) plus
// one default-divider instance (2605 clk/bit).
module tb_ttl_recv;

    localparam int BT1 = 16;
    localparam int BT2 = 2605;

    logic       clk;
    logic       rst_l;
    logic       rx1, rd1, valid1, ferr1, ovr1, busy1;
    logic [7:0] byte1;
    logic       rx2, rd2, valid2, ferr2, ovr2, busy2;
    logic [7:0] byte2;

    int nvec = 0;
    int nmis = 0;
    int ferr_cnt = 0;
    int vrise = 0;
    logic valid_prev = 1'b0;

    ttl_recv #(.BAUD_DIV(13'd15)) u_dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .rx        (rx1),
        .rd        (rd1),
        .byte_out  (byte1),
        .valid     (valid1),
        .frame_err (ferr1),
        .overrun   (ovr1),
        .busy      (busy1)
    );

    ttl_recv u_dut2 (
        .clk       (clk),
        .rst_l     (rst_l),
        .rx        (rx2),
        .rd        (rd2),
        .byte_out  (byte2),
        .valid     (valid2),
        .frame_err (ferr2),
        .overrun   (ovr2),
        .busy      (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ferr1) ferr_cnt++;
        if (valid1 && !valid_prev) vrise++;
        valid_prev = valid1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx2 = v;
        else     rx1 = v;
    endtask

    task automatic send(input bit sel, input logic [7:0] b,
                        input logic stopv, input int bt);
        set_rx(sel, 1'b0);
        repeat (bt) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, b[i]);
            repeat (bt) @(negedge clk);
        end
        set_rx(sel, stopv);
        repeat (bt) @(negedge clk);
    endtask

    task automatic pop1;
        @(negedge clk) rd1 = 1'b1;
        @(negedge clk) rd1 = 1'b0;
    endtask

    int lat;
    int latuse;
    int f0;
    int v0;
    logic [7:0] pb;

    initial begin
        rst_l = 1'b0;
        rx1 = 1'b1; rd1 = 1'b0;
        rx2 = 1'b1; rd2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset1", 32'({byte1, valid1, ferr1, ovr1, busy1}), 32'h0);
        chk("reset2", 32'({byte2, valid2, ferr2, ovr2, busy2}), 32'h0);
        rst_l = 1'b1;
        repeat (4) @(negedge clk);

        // 'A' with latency measurement
        lat = -1;
        v0 = vrise;
        fork
            send(1'b0, 8'h41, 1'b1, BT1);
            begin
                for (int k = 1; k <= 400; k++) begin
                    @(posedge clk);
                    #1;
                    if (valid1) begin
                        lat = k;
                        break;
                    end
                end
            end
        join
        chk("A_lat_ok", 32'(lat >= 153 && lat <= 155), 32'd1);
        chk("A_byte", 32'(byte1), 32'h41);
        chk("A_valid", 32'(valid1), 32'd1);
        chk("A_ferr_cnt", 32'(ferr_cnt), 32'd0);
        chk("A_rises", 32'(vrise - v0), 32'd1);
        latuse = (lat >= 153 && lat <= 155) ? lat : 155;
        pop1();
        @(negedge clk);
        chk("A_pop", 32'(valid1), 32'd0);

        // 5-clock low glitch
        rx1 = 1'b0;
        repeat (5) @(negedge clk);
        rx1 = 1'b1;
        chk("gl_busy_hi", 32'(busy1), 32'd1);
        repeat (10) @(negedge clk);
        chk("gl_busy_lo", 32'(busy1), 32'd0);
        chk("gl_valid", 32'(valid1), 32'd0);
        chk("gl_ferr", 32'(ferr_cnt), 32'd0);

        // framing error then held-low line
        f0 = ferr_cnt;
        send(1'b0, 8'h3C, 1'b0, BT1);
        repeat (100) @(negedge clk);
        chk("fe_pulses", 32'(ferr_cnt - f0), 32'd1);
        chk("fe_valid", 32'(valid1), 32'd0);
        chk("fe_wait_busy", 32'(busy1), 32'd1);
        rx1 = 1'b1;
        repeat (5) @(negedge clk);
        chk("fe_idle", 32'(busy1), 32'd0);
        chk("fe_pulses2", 32'(ferr_cnt - f0), 32'd1);
        send(1'b0, 8'h7E, 1'b1, BT1);
        repeat (2) @(negedge clk);
        chk("7E_byte", 32'(byte1), 32'h7E);
        chk("7E_valid", 32'(valid1), 32'd1);
        pop1();

        // back-to-back without reading
        send(1'b0, 8'h55, 1'b1, BT1);
        send(1'b0, 8'hAA, 1'b1, BT1);
        repeat (2) @(negedge clk);
        chk("ovr_byte", 32'(byte1), 32'hAA);
        chk("ovr_valid", 32'(valid1), 32'd1);
        chk("ovr_flag", 32'(ovr1), 32'd1);
        pop1();
        @(negedge clk);
        chk("ovr_pop_valid", 32'(valid1), 32'd0);
        chk("ovr_pop_flag", 32'(ovr1), 32'd0);

        // rd in the completion cycle
        send(1'b0, 8'h11, 1'b1, BT1);
        repeat (2) @(negedge clk);
        chk("11_byte", 32'(byte1), 32'h11);
        fork
            send(1'b0, 8'h12, 1'b1, BT1);
            begin
                repeat (latuse - 1) @(posedge clk);
                @(negedge clk) rd1 = 1'b1;
                @(negedge clk) rd1 = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        chk("12_byte", 32'(byte1), 32'h12);
        chk("12_valid", 32'(valid1), 32'd1);
        chk("12_ovr", 32'(ovr1), 32'd0);

        // reset mid-frame
        v0 = vrise;
        pb = 8'hF0;
        rx1 = 1'b0;
        repeat (BT1) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx1 = pb[i];
            repeat (BT1) @(negedge clk);
        end
        chk("rst_busy_pre", 32'(busy1), 32'd1);
        rst_l = 1'b0;
        rx1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_outs", 32'({byte1, valid1, ferr1, ovr1, busy1}), 32'h0);
        rst_l = 1'b1;
        repeat (4) @(negedge clk);
        send(1'b0, 8'h0F, 1'b1, BT1);
        repeat (2) @(negedge clk);
        chk("0F_byte", 32'(byte1), 32'h0F);
        chk("0F_valid", 32'(valid1), 32'd1);
        chk("0F_rises", 32'(vrise - v0), 32'd1);

        // default divider instance
        send(1'b1, 8'h41, 1'b1, BT2);
        repeat (2) @(negedge clk);
        chk("d2_byte", 32'(byte2), 32'h41);
        chk("d2_valid", 32'(valid2), 32'd1);
        chk("d2_ferr", 32'(ferr2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
